// File: rtl/l2cache_ctrl.sv
// l2cache_ctrl: per-request sequencing FSM for the L2 cache datapath.
// Orders tag check, inclusive back-invalidate, dirty-victim writeback,
// line fill and response-bus arbitration. Also keeps hit/miss statistics
// and a sticky memory timeout flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a new request, datapath registers ufp address
//   S_TAG   | tag compare; hit -> respond, miss -> start victim handling
//   S_INVAL | one-cycle back-invalidate of the victim line in the L1s
//   S_WB    | writing the dirty victim to memory, waiting on dfp_resp
//   S_ALLOC | reading the missing line from memory, waiting on dfp_resp
//   S_RESP  | requesting the response bus, drive tx on grant
module l2cache_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    output logic             req_ready,
    input  logic             cache_hit,
    input  logic             victim_valid,
    input  logic             victim_dirty,
    output logic             hit_write,
    output logic             evict_update,
    output logic             victim_sel,
    output logic             invalidate,
    output logic             dfp_read,
    output logic             dfp_write,
    input  logic             dfp_resp,
    output logic             write_from_mem,
    output logic             resp_bus_req,
    output logic             resp_bus_busy,
    input  logic             resp_bus_gnt,
    output logic             resp_tx_valid,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_INVAL,
        S_WB,
        S_ALLOC,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             second_pass_q;
    logic [TW-1:0]    tmo_cnt_q;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] hit_count_q, miss_count_q;
    logic             hit_inc, miss_inc;
    logic             dfp_wait;

    // Memory is being waited on: in WB/ALLOC and no completion this cycle.
    assign dfp_wait    = ((state_q == S_WB) || (state_q == S_ALLOC)) && !dfp_resp;
    assign mem_timeout = mem_timeout_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Marks the TAG pass that follows a fill so it does not count as a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  second_pass_q <= 1'b0;
        else if (state_q == S_ALLOC && dfp_resp)   second_pass_q <= 1'b1;
        else if (state_q == S_TAG)                 second_pass_q <= 1'b0;
    end

    // Down-counting is avoided here: the wait counter counts up so it can
    // saturate at TIMEOUT_CYCLES while the FSM keeps waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else if (dfp_wait) begin
            if (tmo_cnt_q != TMO_MAX)  tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (tmo_cnt_q == TMO_LAST) mem_timeout_q <= 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit_inc && hit_count_q != '1)   hit_count_q  <= hit_count_q + CNT_W'(1);
            if (miss_inc && miss_count_q != '1) miss_count_q <= miss_count_q + CNT_W'(1);
        end
    end

    // Next-state and output decode from registered state plus live inputs.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        hit_write      = 1'b0;
        evict_update   = 1'b0;
        victim_sel     = 1'b0;
        invalidate     = 1'b0;
        dfp_read       = 1'b0;
        dfp_write      = 1'b0;
        write_from_mem = 1'b0;
        resp_bus_req   = 1'b0;
        resp_bus_busy  = 1'b0;
        resp_tx_valid  = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_TAG;
            end
            S_TAG: begin
                if (cache_hit) begin
                    if (!second_pass_q) begin
                        evict_update = 1'b1;
                        hit_inc      = 1'b1;
                    end
                    hit_write = req_write;
                    state_d   = S_RESP;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = victim_valid ? S_INVAL : S_ALLOC;
                end
            end
            S_INVAL: begin
                invalidate = 1'b1;
                victim_sel = 1'b1;
                state_d    = victim_dirty ? S_WB : S_ALLOC;
            end
            S_WB: begin
                dfp_write  = 1'b1;
                victim_sel = 1'b1;
                if (dfp_resp) state_d = S_ALLOC;
            end
            S_ALLOC: begin
                dfp_read = 1'b1;
                if (dfp_resp) begin
                    write_from_mem = 1'b1;
                    state_d        = S_TAG;
                end
            end
            S_RESP: begin
                resp_bus_req  = 1'b1;
                resp_bus_busy = 1'b1;
                if (resp_bus_gnt) begin
                    resp_tx_valid = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2cache_ctrl.sv
// Directed bench for l2cache_ctrl. Two instances share stimulus: one with
// default parameters, one with a 4-cycle timeout and 2-bit counters so the
// timeout and counter saturation can be reached quickly.
module tb_l2cache_ctrl;

    logic clk, rst;
    logic req_valid, req_write, cache_hit, victim_valid, victim_dirty;
    logic dfp_resp, resp_bus_gnt;

    logic req_ready, hit_write, evict_update, victim_sel, invalidate;
    logic dfp_read, dfp_write, write_from_mem, resp_bus_req, resp_bus_busy;
    logic resp_tx_valid, mem_timeout;
    logic [31:0] hit_count, miss_count;

    logic t_req_ready, t_hit_write, t_evict_update, t_victim_sel, t_invalidate;
    logic t_dfp_read, t_dfp_write, t_write_from_mem, t_resp_bus_req, t_resp_bus_busy;
    logic t_resp_tx_valid, t_mem_timeout;
    logic [1:0] t_hit_count, t_miss_count;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] R   = 12'h800;
    localparam logic [11:0] HW  = 12'h400;
    localparam logic [11:0] EU  = 12'h200;
    localparam logic [11:0] VS  = 12'h100;
    localparam logic [11:0] INV = 12'h080;
    localparam logic [11:0] DR  = 12'h040;
    localparam logic [11:0] DW  = 12'h020;
    localparam logic [11:0] WFM = 12'h010;
    localparam logic [11:0] BQ  = 12'h008;
    localparam logic [11:0] BB  = 12'h004;
    localparam logic [11:0] TX  = 12'h002;
    localparam logic [11:0] TO  = 12'h001;

    logic [11:0] obs_m, obs_t;
    assign obs_m = {req_ready, hit_write, evict_update, victim_sel, invalidate, dfp_read,
                    dfp_write, write_from_mem, resp_bus_req, resp_bus_busy, resp_tx_valid,
                    mem_timeout};
    assign obs_t = {t_req_ready, t_hit_write, t_evict_update, t_victim_sel, t_invalidate,
                    t_dfp_read, t_dfp_write, t_write_from_mem, t_resp_bus_req,
                    t_resp_bus_busy, t_resp_tx_valid, t_mem_timeout};

    l2cache_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_ready(req_ready), .cache_hit(cache_hit), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .hit_write(hit_write), .evict_update(evict_update),
        .victim_sel(victim_sel), .invalidate(invalidate), .dfp_read(dfp_read),
        .dfp_write(dfp_write), .dfp_resp(dfp_resp), .write_from_mem(write_from_mem),
        .resp_bus_req(resp_bus_req), .resp_bus_busy(resp_bus_busy),
        .resp_bus_gnt(resp_bus_gnt), .resp_tx_valid(resp_tx_valid),
        .mem_timeout(mem_timeout), .hit_count(hit_count), .miss_count(miss_count)
    );

    l2cache_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_ready(t_req_ready), .cache_hit(cache_hit), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .hit_write(t_hit_write),
        .evict_update(t_evict_update), .victim_sel(t_victim_sel),
        .invalidate(t_invalidate), .dfp_read(t_dfp_read), .dfp_write(t_dfp_write),
        .dfp_resp(dfp_resp), .write_from_mem(t_write_from_mem),
        .resp_bus_req(t_resp_bus_req), .resp_bus_busy(t_resp_bus_busy),
        .resp_bus_gnt(resp_bus_gnt), .resp_tx_valid(t_resp_tx_valid),
        .mem_timeout(t_mem_timeout), .hit_count(t_hit_count), .miss_count(t_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The TAG pass right after a fill must see a hit; a miss there is a
    // protocol error on the datapath side.
    logic wfm_d;
    always @(posedge clk or negedge rst) begin
        if (!rst) wfm_d <= 1'b0;
        else begin
            if (wfm_d) assert (cache_hit) else $error("second-pass TAG miss");
            wfm_d <= write_from_mem;
        end
    end

    // Never drive both memory strobes at once.
    always @(negedge clk) begin
        if (rst) assert (!(dfp_read && dfp_write)) else $error("dfp_read and dfp_write together");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [11:0] exp);
        #1;
        chk(tag, 32'(obs_m), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 0; req_write = 0; cache_hit = 0; victim_valid = 0;
        victim_dirty = 0; dfp_resp = 0; resp_bus_gnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        do_reset();

        // 1. read hit, same-cycle grant
        look("t1 reset outs", R);
        chk("t1 reset hits", hit_count, 0);
        chk("t1 reset miss", miss_count, 0);
        req_valid = 1; cache_hit = 1;
        look("t1 idle accept", R);
        cyc(); req_valid = 0;
        look("t1 tag hit", EU);
        cyc(); resp_bus_gnt = 1;
        look("t1 resp gnt", BQ | BB | TX);
        cyc(); resp_bus_gnt = 0;
        look("t1 back idle", R);
        chk("t1 hit_count", hit_count, 1);
        chk("t1 miss_count", miss_count, 0);

        // 2. clean miss, fill after 5 cycles
        do_reset();
        req_valid = 1; cache_hit = 0; victim_valid = 1; victim_dirty = 0;
        look("t2 idle", R);
        cyc(); req_valid = 0;
        look("t2 tag miss", 12'h000);
        cyc();
        look("t2 inval", INV | VS);
        for (int i = 0; i < 4; i++) begin
            cyc();
            look("t2 alloc wait", DR);
        end
        cyc(); dfp_resp = 1; cache_hit = 1;
        look("t2 alloc resp", DR | WFM);
        cyc(); dfp_resp = 0;
        look("t2 tag pass2", 12'h000);
        cyc(); resp_bus_gnt = 1;
        look("t2 resp", BQ | BB | TX);
        cyc(); resp_bus_gnt = 0;
        look("t2 idle", R);
        chk("t2 miss_count", miss_count, 1);
        chk("t2 hit_count", hit_count, 0);

        // 3. dirty write miss
        do_reset();
        req_valid = 1; req_write = 1; cache_hit = 0; victim_valid = 1; victim_dirty = 1;
        look("t3 idle", R);
        cyc(); req_valid = 0;
        look("t3 tag miss", 12'h000);
        cyc();
        look("t3 inval", INV | VS);
        cyc();
        look("t3 wb wait0", DW | VS);
        cyc();
        look("t3 wb wait1", DW | VS);
        cyc(); dfp_resp = 1;
        look("t3 wb resp", DW | VS);
        cyc(); dfp_resp = 0;
        look("t3 alloc wait", DR);
        cyc(); dfp_resp = 1; cache_hit = 1;
        look("t3 alloc resp", DR | WFM);
        cyc(); dfp_resp = 0;
        look("t3 tag write", HW);
        cyc(); resp_bus_gnt = 1;
        look("t3 resp", BQ | BB | TX);
        cyc(); resp_bus_gnt = 0; req_write = 0;
        look("t3 idle", R);
        chk("t3 miss_count", miss_count, 1);
        chk("t3 hit_count", hit_count, 0);

        // 4. invalid victim; stray dfp_resp ignored outside WB/ALLOC
        do_reset();
        dfp_resp = 1;
        look("t4 stray resp idle", R);
        cyc(); dfp_resp = 0;
        look("t4 still idle", R);
        req_valid = 1; cache_hit = 0; victim_valid = 0;
        look("t4 accept", R);
        cyc(); req_valid = 0;
        look("t4 tag miss", 12'h000);
        cyc(); dfp_resp = 1; cache_hit = 1;
        look("t4 alloc resp", DR | WFM);
        cyc(); dfp_resp = 0;
        look("t4 tag pass2", 12'h000);
        cyc(); dfp_resp = 1;
        look("t4 resp stray", BQ | BB);
        cyc(); dfp_resp = 0; resp_bus_gnt = 1;
        look("t4 resp gnt", BQ | BB | TX);
        cyc(); resp_bus_gnt = 0;
        look("t4 idle", R);
        chk("t4 miss_count", miss_count, 1);

        // 5. arbiter stall for 10 cycles with req_valid held
        do_reset();
        req_valid = 1; cache_hit = 1;
        look("t5 idle", R);
        cyc();
        look("t5 tag", EU);
        for (int i = 0; i < 10; i++) begin
            cyc();
            look("t5 stall", BQ | BB);
        end
        cyc(); resp_bus_gnt = 1;
        look("t5 gnt", BQ | BB | TX);
        cyc(); resp_bus_gnt = 0; req_valid = 0;
        look("t5 idle", R);
        chk("t5 hit_count", hit_count, 1);

        // 6. timeout (4-cycle instance) then async reset mid-ALLOC
        do_reset();
        req_valid = 1; cache_hit = 0; victim_valid = 0;
        look("t6 idle", R);
        cyc(); req_valid = 0;
        look("t6 tag", 12'h000);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("t6 alloc pre-timeout", 32'(obs_t), 32'(DR));
        end
        cyc(); #1;
        chk("t6 timeout set", 32'(obs_t), 32'(DR | TO));
        chk("t6 main no timeout", 32'(obs_m), 32'(DR));
        cyc(); #1;
        chk("t6 timeout sticky", 32'(obs_t), 32'(DR | TO));
        rst = 0;
        #1;
        chk("t6 async reset outs", 32'(obs_t), 32'(R));
        chk("t6 async reset miss", 32'(t_miss_count), 0);
        chk("t6 async reset main", 32'(obs_m), 32'(R));
        @(posedge clk); #1;
        rst = 1;

        // 7. counter saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; cache_hit = 1;
            cyc(); req_valid = 0;
            cyc(); resp_bus_gnt = 1;
            cyc(); resp_bus_gnt = 0;
        end
        #1;
        chk("t7 main hits", hit_count, 4);
        chk("t7 sat hits", 32'(t_hit_count), 3);
        chk("t7 sat misses", 32'(t_miss_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
